slc3_mem_responder: RTL and testbench

//  Memory-side responder for the SLC-3 CPU memory interface: services CPU read/write strobes
//  on ADDR/OE/WE with on-chip RAM plus one memory-mapped I/O word. Handshakes completion
//  to the ISDU via a ready pulse R after programmable wait states.

---
 rtl/slc3_mem_pkg.sv | 20 ++
 rtl/slc3_mem_responder_sram.sv | 23 ++
 rtl/slc3_mem_responder.sv | 139 +++++++++++++
 tb/tb_slc3_mem_responder.sv | 178 +++++++++++++++++
 4 files changed

// File: rtl/slc3_mem_pkg.sv
// Shared types and constants for the SLC-3 memory responder.
package slc3_mem_pkg;

  // Access sequencing: accept in IDLE, count wait states, pulse ready, wait for strobe release.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2,
    HOLD = 2'd3
  } mem_state_t;

  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } mem_op_t;

  // Default address of the memory-mapped switches / hex-display word.
  localparam logic [15:0] IO_ADDR_DEFAULT = 16'hFFFF;

endpackage

// File: rtl/slc3_mem_responder_sram.sv
// Single-port synchronous RAM, 16-bit words, one-cycle registered read.
module slc3_sram_array #(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [15:0]       wdata,
  output logic [15:0]       rdata
);

  logic [15:0] mem [2**ADDR_W];
  logic [15:0] rdata_q;

  // Write-first is not needed: read returns the pre-write word at the same address.
  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
    rdata_q <= mem[addr];
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/slc3_mem_responder.sv
// Memory-side responder: RAM plus one memory-mapped I/O word, ready pulse after wait states.
//
// Handshake: the CPU requests an access by driving OE or WE low (WE wins). The request is
// taken on the first edge that sees a low strobe while IDLE; address/data/op are latched
// then and later bus changes are ignored. R is high for exactly one cycle when the access
// completes. The block then waits in HOLD until both strobes are high before it can accept
// again, so a strobe that stays low never starts a second access.
module slc3_mem_responder
  import slc3_mem_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter int          WAIT_CYCLES = 2,
  parameter logic [15:0] IO_ADDR     = IO_ADDR_DEFAULT
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [15:0] ADDR,
  input  logic        OE,
  input  logic        WE,
  input  logic [15:0] Data_from_CPU,
  input  logic [9:0]  Switches,
  output logic [15:0] Data_to_CPU,
  output logic        R,
  output logic [15:0] HEX_DATA,
  output logic        Busy,
  output mem_state_t  dbg_state
);

  mem_state_t  state_q, state_d;
  mem_op_t     op_q, op_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic [15:0] dout_q, dout_d;
  logic [15:0] hex_q, hex_d;
  logic        busy_q, busy_d;

  logic              is_io, in_ram, capture;
  logic [15:0]       sel_word;
  logic              ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [15:0]       ram_rdata;

  // Decode the latched address and pick the word a read would return.
  always_comb begin
    is_io    = (addr_q == IO_ADDR);
    in_ram   = ((addr_q >> ADDR_W) == 16'h0000);
    sel_word = 16'h0000;
    if (is_io)       sel_word = {6'b0, Switches};
    else if (in_ram) sel_word = ram_rdata;
    // With no wait states the RAM word only becomes valid during DONE, so capture there.
    if (WAIT_CYCLES == 0) capture = (op_q == OP_READ) && (state_q == DONE);
    else                  capture = (op_q == OP_READ) && (state_q == WAIT) && (cnt_q == 4'd1);
  end

  // RAM is addressed from the live bus while IDLE so the read starts at accept.
  always_comb begin
    ram_addr = (state_q == IDLE) ? ADDR[ADDR_W-1:0] : addr_q[ADDR_W-1:0];
    ram_we   = (state_q == DONE) && (op_q == OP_WRITE) && !is_io && in_ram && !Reset;
  end

  // Next-state and datapath updates for the access FSM.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    dout_d  = dout_q;
    hex_d   = hex_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (!WE || !OE) begin
          addr_d  = ADDR;
          wdata_d = Data_from_CPU;
          op_d    = !WE ? OP_WRITE : OP_READ;
          cnt_d   = 4'(WAIT_CYCLES);
          busy_d  = 1'b1;
          state_d = (WAIT_CYCLES == 0) ? DONE : WAIT;
        end
      end
      WAIT: begin
        cnt_d = cnt_q - 4'd1;
        if (cnt_q == 4'd1) state_d = DONE;
      end
      DONE: begin
        state_d = HOLD;
        if (op_q == OP_WRITE && is_io) hex_d = wdata_q;
      end
      HOLD: begin
        if (OE && WE) begin
          state_d = IDLE;
          busy_d  = 1'b0;
        end
      end
      default: state_d = IDLE;
    endcase
    if (capture) dout_d = sel_word;
  end

  // State and output registers; reset abandons any access in flight.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= IDLE;
      op_q    <= OP_READ;
      cnt_q   <= 4'd0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      dout_q  <= 16'h0000;
      hex_q   <= 16'h0000;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      dout_q  <= dout_d;
      hex_q   <= hex_d;
      busy_q  <= busy_d;
    end
  end

  slc3_sram_array #(.ADDR_W(ADDR_W)) u_sram (
    .clk   (Clk),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (wdata_q),
    .rdata (ram_rdata)
  );

  assign R           = (state_q == DONE);
  assign Busy        = busy_q;
  assign Data_to_CPU = dout_q;
  assign HEX_DATA    = hex_q;
  assign dbg_state   = state_q;

endmodule

// File: tb/tb_slc3_mem_responder.sv
// Directed bench for slc3_mem_responder: a 2-wait-state instance and a 0-wait-state instance.
module tb_slc3_mem_responder;
  import slc3_mem_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        Reset = 1'b1;
  logic [15:0] ADDR = 16'h0000;
  logic [15:0] Data_from_CPU = 16'h0000;
  logic [9:0]  Switches = 10'h000;
  logic        OE = 1'b1, WE = 1'b1;
  logic        OE0 = 1'b1, WE0 = 1'b1;

  logic [15:0] dout, hex, dout0, hex0;
  logic        r, busy, r0, busy0;
  mem_state_t  st, st0;

  slc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(2), .IO_ADDR(16'hFFFF)) dut (
    .Clk(clk), .Reset(Reset), .ADDR(ADDR), .OE(OE), .WE(WE),
    .Data_from_CPU(Data_from_CPU), .Switches(Switches),
    .Data_to_CPU(dout), .R(r), .HEX_DATA(hex), .Busy(busy), .dbg_state(st)
  );

  slc3_mem_responder #(.ADDR_W(10), .WAIT_CYCLES(0), .IO_ADDR(16'hFFFF)) dut0 (
    .Clk(clk), .Reset(Reset), .ADDR(ADDR), .OE(OE0), .WE(WE0),
    .Data_from_CPU(Data_from_CPU), .Switches(Switches),
    .Data_to_CPU(dout0), .R(r0), .HEX_DATA(hex0), .Busy(busy0), .dbg_state(st0)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [15:0] exp_q[$];

  task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Ready-pulse counters, sampled mid-cycle.
  int r_cnt = 0, r0_cnt = 0;
  always @(negedge clk) begin
    if (r)  r_cnt++;
    if (r0) r0_cnt++;
  end

  // ---------------- driver tasks ----------------
  task automatic do_reset();
    @(posedge clk); #1;
    Reset = 1'b1; OE = 1'b1; WE = 1'b1; OE0 = 1'b1; WE0 = 1'b1;
    repeat (2) @(posedge clk);
    #1 Reset = 1'b0;
  endtask

  // One full access. lat = edges from strobe assertion to the cycle R is seen (0 = timeout).
  task automatic access(input int which, input logic wr, input logic both,
                        input logic [15:0] a, input logic [15:0] d, output int lat);
    @(posedge clk); #1;
    ADDR = a; Data_from_CPU = d;
    if (which == 0) begin
      if (wr || both) WE = 1'b0;
      if (!wr || both) OE = 1'b0;
    end else begin
      if (wr || both) WE0 = 1'b0;
      if (!wr || both) OE0 = 1'b0;
    end
    lat = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk); #1;
      if ((which == 0) ? r : r0) begin
        lat = i;
        break;
      end
    end
    OE = 1'b1; WE = 1'b1; OE0 = 1'b1; WE0 = 1'b1;
    ADDR = 16'h0000; Data_from_CPU = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
  endtask

  // ---------------- directed sequence ----------------
  int lat;
  int r_before;

  initial begin
    do_reset();

    // Reset state
    check("rst_r", {15'b0, r}, 16'h0000);
    check("rst_busy", {15'b0, busy}, 16'h0000);
    check("rst_dout", dout, 16'h0000);
    check("rst_hex", hex, 16'h0000);
    check("rst_state", {14'b0, st}, {14'b0, IDLE});

    // 1. RAM write then read, latency WAIT_CYCLES+1
    access(0, 1'b1, 1'b0, 16'h0010, 16'hBEEF, lat);
    check("t1_wr_lat", 16'(lat), 16'd3);
    check("t1_wr_dout_kept", dout, 16'h0000);
    access(0, 1'b0, 1'b0, 16'h0010, 16'h0000, lat);
    check("t1_rd_lat", 16'(lat), 16'd3);
    exp_q.push_back(16'hBEEF);
    check("t1_rd_data", dout, exp_q.pop_front());
    check("t1_busy_idle", {15'b0, busy}, 16'h0000);

    // 2. Memory-mapped I/O
    access(0, 1'b1, 1'b0, 16'h03FF, 16'h7777, lat);
    Switches = 10'h2A5;
    access(0, 1'b0, 1'b0, 16'hFFFF, 16'h0000, lat);
    check("t2_sw_read", dout, 16'h02A5);
    access(0, 1'b1, 1'b0, 16'hFFFF, 16'h1234, lat);
    check("t2_hex", hex, 16'h1234);
    check("t2_dout_kept", dout, 16'h02A5);
    access(0, 1'b0, 1'b0, 16'h03FF, 16'h0000, lat);
    check("t2_ram_untouched", dout, 16'h7777);

    // 3. Out-of-range address
    access(0, 1'b1, 1'b0, 16'h0000, 16'h1111, lat);
    access(0, 1'b0, 1'b0, 16'h8000, 16'h0000, lat);
    check("t3_oor_lat", 16'(lat), 16'd3);
    check("t3_oor_data", dout, 16'h0000);
    access(0, 1'b1, 1'b0, 16'h8000, 16'h5555, lat);
    check("t3_oor_wr_lat", 16'(lat), 16'd3);
    access(0, 1'b0, 1'b0, 16'h0000, 16'h0000, lat);
    check("t3_no_alias", dout, 16'h1111);

    // 4. OE held low for 20 cycles gives one access
    r_before = r_cnt;
    @(posedge clk); #1;
    ADDR = 16'h0010; OE = 1'b0;
    repeat (20) @(posedge clk);
    #1;
    check("t4_busy_held", {15'b0, busy}, 16'h0001);
    check("t4_one_pulse", 16'(r_cnt - r_before), 16'd1);
    check("t4_data", dout, 16'hBEEF);
    OE = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("t4_busy_release", {15'b0, busy}, 16'h0000);

    // 5. Reset during the wait states of a write
    access(0, 1'b1, 1'b0, 16'h0020, 16'h2222, lat);
    r_before = r_cnt;
    @(posedge clk); #1;
    ADDR = 16'h0020; Data_from_CPU = 16'hAAAA; WE = 1'b0;
    @(posedge clk); #1;
    check("t5_accepted", {15'b0, busy}, 16'h0001);
    Reset = 1'b1; WE = 1'b1;
    @(posedge clk); #1;
    Reset = 1'b0;
    check("t5_state", {14'b0, st}, {14'b0, IDLE});
    check("t5_busy", {15'b0, busy}, 16'h0000);
    check("t5_dout", dout, 16'h0000);
    check("t5_hex", hex, 16'h0000);
    repeat (4) @(posedge clk);
    #1;
    check("t5_no_r", 16'(r_cnt - r_before), 16'd0);
    access(0, 1'b0, 1'b0, 16'h0020, 16'h0000, lat);
    check("t5_word_kept", dout, 16'h2222);

    // 6. Zero-wait-state instance, both strobes low means write
    access(1, 1'b0, 1'b1, 16'h0003, 16'h0F0F, lat);
    check("t6_lat", 16'(lat), 16'd1);
    check("t6_dout_unchanged", dout0, 16'h0000);
    access(1, 1'b0, 1'b0, 16'h0003, 16'h0000, lat);
    check("t6_rd_lat", 16'(lat), 16'd1);
    check("t6_rd_data", dout0, 16'h0F0F);

    // ---------------- report ----------------
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
